// File: rtl/led_adder_pkg.sv
// Shared seven-segment glyph constants and the hex-to-segment lookup for the adder display.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package led_adder_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
        logic [SEG_W-1:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit hex to seven-segment glyph decoder used by the display mux.
module seg7_hex_decoder
    import led_adder_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = hex_to_seg(nibble);
    end

endmodule

// File: rtl/led_adder_scan.sv
// Operand sequencer, registered adder and multiplexed hex display with run/single-step control.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero digits above digit 0.
module led_adder_scan
    import led_adder_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 2**20,
    parameter int unsigned UPD_DIV  = 2**27,
    parameter int unsigned STEP_X   = 1,
    parameter int unsigned STEP_Y   = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run,
    input  logic              step,
    output logic [DIGITS-1:0] led_mux,
    output logic [6:0]        led,
    output logic [WIDTH-1:0]  sum_o,
    output logic              cout_o
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned UPD_W  = $clog2(UPD_DIV);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned R_W    = 4 * DIGITS;

    generate
        if (R_W < WIDTH + 1) begin : g_digits_too_few
            $error("led_adder_scan: DIGITS too small to display WIDTH+1 result bits");
        end
        if (SCAN_DIV < 2 || UPD_DIV < 2) begin : g_div_too_small
            $error("led_adder_scan: SCAN_DIV and UPD_DIV must be at least 2");
        end
    endgenerate

    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  digit_idx;
    logic [IDX_W-1:0]  idx_next_c;
    logic [UPD_W-1:0]  upd_cnt;
    logic              step_q;
    logic              upd_tick_c;
    logic              step_edge_c;
    logic              upd_en_c;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic [R_W-1:0]    r_c;
    logic [3:0]        nibble_c;
    logic [6:0]        glyph_c;

    // Digit scan: one slot per SCAN_DIV cycles, index wraps after the last digit.
    always_comb begin
        idx_next_c = digit_idx + IDX_W'(1);
        if (digit_idx == IDX_W'(DIGITS - 1)) begin
            idx_next_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            led_mux   <= DIGITS'(1);
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= idx_next_c;
            led_mux   <= DIGITS'(1) << idx_next_c;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    // Update prescaler only advances in run mode, so a paused count resumes where it stopped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            upd_cnt <= '0;
        end else if (run) begin
            if (upd_tick_c) begin
                upd_cnt <= '0;
            end else begin
                upd_cnt <= upd_cnt + UPD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    always_comb begin
        upd_tick_c  = run && (upd_cnt == UPD_W'(UPD_DIV - 1));
        step_edge_c = step && !step_q && !run;
        upd_en_c    = upd_tick_c || step_edge_c;
    end

    // Operand generators wrap silently modulo 2**WIDTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x <= '0;
            y <= '0;
        end else if (upd_en_c) begin
            x <= x + WIDTH'(STEP_X);
            y <= y + WIDTH'(STEP_Y);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {cout_o, sum_o} <= '0;
        end else begin
            {cout_o, sum_o} <= (WIDTH+1)'(x) + (WIDTH+1)'(y);
        end
    end

    // Display path: select the nibble of the full result for the active digit.
    always_comb begin
        r_c      = R_W'({cout_o, sum_o});
        nibble_c = r_c[3:0];
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (digit_idx == IDX_W'(k)) begin
                nibble_c = r_c[4*k +: 4];
            end
        end
    end

    seg7_hex_decoder u_dec (
        .nibble (nibble_c),
        .seg_c  (glyph_c)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero_c;

    always_comb begin
        upper_zero_c = 1'b0;
        for (int k = 1; k < int'(DIGITS); k++) begin
            if (digit_idx == IDX_W'(k)) begin
                upper_zero_c = ((r_c >> (4*k)) == '0);
            end
        end
        led = upper_zero_c ? SEG_BLANK : glyph_c;
    end
`else
    always_comb begin
        led = glyph_c;
    end
`endif

endmodule
